// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - round score, lives and countdown timer tracker
//
// Purpose: keeps the score, remaining lives and remaining seconds for one game
// round, driven by the game master state and edge events from the game engine.
//
// Ports:
//   CLK            in   system clock, all state changes on the rising edge
//   RESET          in   synchronous active-high reset
//   MASTER_STATE   in   2  00 idle, 01 play, 10 win, 11 lost
//   TARGET_REACHED in   rising edge = one target hit
//   COLLISION      in   rising edge = one collision
//   BTNU           in   rising edge = one restart request
//   CURRENT_SCORE  out  4  score 0..10
//   GAME_OVER      out  loss flag
//   LIVES          out  2  remaining lives
//   TIME_LEFT      out  6  remaining seconds
//   SCORE_EVENT    out  one-cycle pulse per score increment

module score_tracker #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int TIME_LIMIT    = 60,
  parameter int START_LIVES   = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MASTER_STATE,
  input  logic       TARGET_REACHED,
  input  logic       COLLISION,
  input  logic       BTNU,
  output logic [3:0] CURRENT_SCORE,
  output logic       GAME_OVER,
  output logic [1:0] LIVES,
  output logic [5:0] TIME_LEFT,
  output logic       SCORE_EVENT
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);
  localparam logic [5:0]    TIME_INIT  = 6'(TIME_LIMIT);
  localparam logic [3:0]    SCORE_MAX  = 4'd10;

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_PLAY = 2'b01,
    M_WIN  = 2'b10,
    M_LOST = 2'b11
  } master_t;

  master_t       master;
  logic          target_d, collision_d, btnu_d;
  logic          hit, crash, restart, tick, winning_hit;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    score_n;
  logic          game_over_n;
  logic [1:0]    lives_n;
  logic [5:0]    time_n;
  logic          event_n;

  assign master  = master_t'(MASTER_STATE);

  // Reset clears the delay registers, so a level already high when reset
  // releases is seen as a fresh edge on the first sample.
  assign hit     = TARGET_REACHED & ~target_d;
  assign crash   = COLLISION & ~collision_d;
  assign restart = BTNU & ~btnu_d;
  assign tick    = (presc == PRESC_LAST);

  // The hit that reaches the maximum score wins the round outright; any
  // collision or timeout landing in the same cycle is dropped.
  assign winning_hit = hit && (CURRENT_SCORE == SCORE_MAX - 4'd1);

  always_comb begin
    score_n     = CURRENT_SCORE;
    game_over_n = GAME_OVER;
    lives_n     = LIVES;
    time_n      = TIME_LEFT;
    event_n     = 1'b0;
    presc_n     = presc;
    case (master)
      M_IDLE: begin
        score_n     = 4'd0;
        game_over_n = 1'b0;
        lives_n     = LIVES_INIT;
        time_n      = TIME_INIT;
        presc_n     = '0;
      end
      M_PLAY: begin
        // After a loss everything, prescaler included, stays frozen.
        if (!GAME_OVER) begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (hit && (CURRENT_SCORE < SCORE_MAX)) begin
            score_n = CURRENT_SCORE + 4'd1;
            event_n = 1'b1;
          end
          if (!winning_hit) begin
            if (crash) begin
              lives_n = LIVES - 2'd1;
              if (LIVES == 2'd1) game_over_n = 1'b1;
            end
            if (tick) begin
              time_n = TIME_LEFT - 6'd1;
              if (TIME_LEFT == 6'd1) game_over_n = 1'b1;
            end
          end
        end
      end
      M_WIN: begin
        if (restart) begin
          score_n = 4'd0;
          lives_n = LIVES_INIT;
          time_n  = TIME_INIT;
          presc_n = '0;
        end
      end
      M_LOST: begin
        if (restart) begin
          score_n     = 4'd0;
          lives_n     = LIVES_INIT;
          time_n      = TIME_INIT;
          presc_n     = '0;
          game_over_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      CURRENT_SCORE <= 4'd0;
      GAME_OVER     <= 1'b0;
      LIVES         <= LIVES_INIT;
      TIME_LEFT     <= TIME_INIT;
      SCORE_EVENT   <= 1'b0;
      presc         <= '0;
      target_d      <= 1'b0;
      collision_d   <= 1'b0;
      btnu_d        <= 1'b0;
    end else begin
      CURRENT_SCORE <= score_n;
      GAME_OVER     <= game_over_n;
      LIVES         <= lives_n;
      TIME_LEFT     <= time_n;
      SCORE_EVENT   <= event_n;
      presc         <= presc_n;
      target_d      <= TARGET_REACHED;
      collision_d   <= COLLISION;
      btnu_d        <= BTNU;
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// tb/tb_score_tracker.sv - self-checking bench for score_tracker

module tb_score_tracker;

  localparam int TPS = 4;
  localparam int TL  = 3;
  localparam int SL  = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] MASTER_STATE = 2'b00;
  logic       TARGET_REACHED = 1'b0;
  logic       COLLISION = 1'b0;
  logic       BTNU = 1'b0;
  logic [3:0] CURRENT_SCORE;
  logic       GAME_OVER;
  logic [1:0] LIVES;
  logic [5:0] TIME_LEFT;
  logic       SCORE_EVENT;

  int tests = 0;
  int fails = 0;

  // Reference model state, plain integers.
  int m_score = 0, m_go = 0, m_lives = SL, m_time = TL, m_ev = 0;
  int m_elapsed = 0;
  int p_tr = 0, p_col = 0, p_btn = 0;

  score_tracker #(.TICKS_PER_SEC(TPS), .TIME_LIMIT(TL), .START_LIVES(SL)) dut (
    .CLK(CLK), .RESET(RESET), .MASTER_STATE(MASTER_STATE),
    .TARGET_REACHED(TARGET_REACHED), .COLLISION(COLLISION), .BTNU(BTNU),
    .CURRENT_SCORE(CURRENT_SCORE), .GAME_OVER(GAME_OVER), .LIVES(LIVES),
    .TIME_LEFT(TIME_LEFT), .SCORE_EVENT(SCORE_EVENT)
  );

  always #5 CLK = ~CLK;

  task automatic model_restore();
    m_score = 0; m_lives = SL; m_time = TL; m_elapsed = 0;
  endtask

  // One clock edge of game rules applied to the inputs present at that edge.
  task automatic model_step();
    bit h, c, b, won, tick;
    if (RESET) begin
      model_restore(); m_go = 0; m_ev = 0;
      p_tr = 0; p_col = 0; p_btn = 0;
      return;
    end
    h = TARGET_REACHED && !p_tr;
    c = COLLISION && !p_col;
    b = BTNU && !p_btn;
    m_ev = 0;
    case (MASTER_STATE)
      2'b00: begin model_restore(); m_go = 0; end
      2'b01: if (!m_go) begin
        m_elapsed++;
        tick = (m_elapsed == TPS);
        if (tick) m_elapsed = 0;
        won = 0;
        if (h && m_score < 10) begin
          m_score++; m_ev = 1;
          won = (m_score == 10);
        end
        if (!won) begin
          if (c) begin m_lives--; if (m_lives == 0) m_go = 1; end
          if (tick) begin m_time--; if (m_time == 0) m_go = 1; end
        end
      end
      2'b10: if (b) model_restore();
      default: if (b) begin model_restore(); m_go = 0; end
    endcase
    p_tr = TARGET_REACHED; p_col = COLLISION; p_btn = BTNU;
  endtask

  // Drive at the falling edge, clock once, return at the next falling edge.
  task automatic cyc(input logic r, input logic [1:0] s, input logic t, input logic c, input logic b);
    RESET = r; MASTER_STATE = s; TARGET_REACHED = t; COLLISION = c; BTNU = b;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    cyc(1, 2'b01, 1, 1, 1);
    tests++;
    if ({CURRENT_SCORE, GAME_OVER, LIVES, TIME_LEFT, SCORE_EVENT} !== {4'd0, 1'b0, 2'd3, 6'd3, 1'b0}) begin
      fails++;
      $display("FAIL reset: got score=%0d go=%0d lives=%0d time=%0d ev=%0d, want 0 0 3 3 0",
               CURRENT_SCORE, GAME_OVER, LIVES, TIME_LEFT, SCORE_EVENT);
    end
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_hits();
    cyc(0, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      cyc(0, 2'b01, 1, 0, 0);
      tests++;
      if (CURRENT_SCORE !== 4'((i < 10) ? i : 10) || SCORE_EVENT !== (i <= 10)) begin
        fails++;
        $display("FAIL hit_%0d: got score=%0d ev=%0d, want %0d %0d", i, CURRENT_SCORE, SCORE_EVENT,
                 (i < 10) ? i : 10, (i <= 10));
      end
      cyc(0, 2'b10, 0, 0, 0);
      tests++;
      if (SCORE_EVENT !== 1'b0) begin
        fails++;
        $display("FAIL hit_pulse_%0d: got ev=%0d, want 0", i, SCORE_EVENT);
      end
    end
  endtask

  task automatic test_collisions();
    cyc(0, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 2'b01, 0, 1, 0);
      tests++;
      if (LIVES !== 2'(3 - i) || GAME_OVER !== (i == 3)) begin
        fails++;
        $display("FAIL collision_%0d: got lives=%0d go=%0d, want %0d %0d", i, LIVES, GAME_OVER, 3 - i, (i == 3));
      end
      cyc(0, 2'b01, 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 2'b01, 1, 0, 0);
      cyc(0, 2'b01, 0, 0, 0);
    end
    tests++;
    if (CURRENT_SCORE !== 4'd0 || SCORE_EVENT !== 1'b0) begin
      fails++;
      $display("FAIL frozen_after_loss: got score=%0d ev=%0d, want 0 0", CURRENT_SCORE, SCORE_EVENT);
    end
  endtask

  task automatic test_timeout();
    cyc(0, 2'b00, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 2'b01, 0, 0, 0);
      if (k % 4 == 0) begin
        tests++;
        if (TIME_LEFT !== 6'(3 - k / 4) || GAME_OVER !== (k == 12)) begin
          fails++;
          $display("FAIL timeout_%0d: got time=%0d go=%0d, want %0d %0d", k, TIME_LEFT, GAME_OVER, 3 - k / 4, (k == 12));
        end
      end
    end
    cyc(0, 2'b11, 0, 0, 1);
    tests++;
    if ({CURRENT_SCORE, GAME_OVER, LIVES, TIME_LEFT} !== {4'd0, 1'b0, 2'd3, 6'd3}) begin
      fails++;
      $display("FAIL lost_restart: got score=%0d go=%0d lives=%0d time=%0d, want 0 0 3 3",
               CURRENT_SCORE, GAME_OVER, LIVES, TIME_LEFT);
    end
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_win_priority();
    cyc(0, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 2'b01, 1, (i <= 2), 0);
      cyc(0, 2'b10, 0, 0, 0);
    end
    tests++;
    if (CURRENT_SCORE !== 4'd9 || LIVES !== 2'd1) begin
      fails++;
      $display("FAIL win_setup: got score=%0d lives=%0d, want 9 1", CURRENT_SCORE, LIVES);
    end
    cyc(0, 2'b01, 1, 1, 0);
    tests++;
    if ({CURRENT_SCORE, GAME_OVER, LIVES, SCORE_EVENT} !== {4'd10, 1'b0, 2'd1, 1'b1}) begin
      fails++;
      $display("FAIL win_priority: got score=%0d go=%0d lives=%0d ev=%0d, want 10 0 1 1",
               CURRENT_SCORE, GAME_OVER, LIVES, SCORE_EVENT);
    end
  endtask

  task automatic test_double_loss();
    cyc(0, 2'b00, 0, 0, 0);
    cyc(0, 2'b01, 0, 1, 0);
    cyc(0, 2'b10, 0, 0, 0);
    cyc(0, 2'b01, 0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(0, 2'b01, 0, 0, 0);
    tests++;
    if (LIVES !== 2'd1 || TIME_LEFT !== 6'd1 || GAME_OVER !== 1'b0) begin
      fails++;
      $display("FAIL double_setup: got lives=%0d time=%0d go=%0d, want 1 1 0", LIVES, TIME_LEFT, GAME_OVER);
    end
    cyc(0, 2'b01, 0, 1, 0);
    tests++;
    if ({GAME_OVER, LIVES, TIME_LEFT} !== {1'b1, 2'd0, 6'd0}) begin
      fails++;
      $display("FAIL double_loss: got go=%0d lives=%0d time=%0d, want 1 0 0", GAME_OVER, LIVES, TIME_LEFT);
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 2'b01, 1, (i == 1), 0);
      cyc(0, 2'b10, 0, 0, 0);
    end
    tests++;
    if (CURRENT_SCORE !== 4'd5 || LIVES !== 2'd2 || TIME_LEFT !== 6'd2) begin
      fails++;
      $display("FAIL midround_setup: got score=%0d lives=%0d time=%0d, want 5 2 2", CURRENT_SCORE, LIVES, TIME_LEFT);
    end
    cyc(1, 2'b01, 1, 0, 0);
    tests++;
    if ({CURRENT_SCORE, LIVES, TIME_LEFT, SCORE_EVENT} !== {4'd0, 2'd3, 6'd3, 1'b0}) begin
      fails++;
      $display("FAIL reset_priority: got score=%0d lives=%0d time=%0d ev=%0d, want 0 3 3 0",
               CURRENT_SCORE, LIVES, TIME_LEFT, SCORE_EVENT);
    end
    cyc(0, 2'b01, 1, 0, 0);
    tests++;
    if (CURRENT_SCORE !== 4'd1 || SCORE_EVENT !== 1'b1) begin
      fails++;
      $display("FAIL held_across_reset: got score=%0d ev=%0d, want 1 1", CURRENT_SCORE, SCORE_EVENT);
    end
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_btn_hold();
    cyc(0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 2'b01, 1, 0, 0);
      cyc(0, 2'b10, 0, 0, 0);
    end
    cyc(0, 2'b10, 0, 0, 1);
    tests++;
    if ({CURRENT_SCORE, LIVES, TIME_LEFT} !== {4'd0, 2'd3, 6'd3}) begin
      fails++;
      $display("FAIL win_restart: got score=%0d lives=%0d time=%0d, want 0 3 3", CURRENT_SCORE, LIVES, TIME_LEFT);
    end
    cyc(0, 2'b01, 1, 0, 1);
    for (int j = 0; j < 3; j++) cyc(0, 2'b10, 0, 0, 1);
    tests++;
    if (CURRENT_SCORE !== 4'd1) begin
      fails++;
      $display("FAIL btn_held: got score=%0d, want 1", CURRENT_SCORE);
    end
    cyc(0, 2'b10, 0, 0, 0);
    cyc(0, 2'b10, 0, 0, 1);
    tests++;
    if (CURRENT_SCORE !== 4'd0) begin
      fails++;
      $display("FAIL btn_rearm: got score=%0d, want 0", CURRENT_SCORE);
    end
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [13:0] got, want;
    logic [1:0]  s;
    int          r;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      s = (r < 70) ? 2'b01 : (r < 80) ? 2'b00 : (r < 90) ? 2'b10 : 2'b11;
      cyc(($urandom_range(0, 99) == 0), s, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) < 3));
      got  = {CURRENT_SCORE, GAME_OVER, LIVES, TIME_LEFT, SCORE_EVENT};
      want = {4'(m_score), 1'(m_go), 2'(m_lives), 6'(m_time), 1'(m_ev)};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL random_%0d: got score=%0d go=%0d lives=%0d time=%0d ev=%0d, want %0d %0d %0d %0d %0d",
                 n, CURRENT_SCORE, GAME_OVER, LIVES, TIME_LEFT, SCORE_EVENT,
                 m_score, m_go, m_lives, m_time, m_ev);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_hits();
    test_collisions();
    test_timeout();
    test_win_priority();
    test_double_loss();
    test_reset_mid();
    test_btn_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100000000, CLK cycles per game second.
REQ-002 Parameter TIME_LIMIT, default 60, seconds per round, range 1..63.
REQ-003 Parameter START_LIVES, default 3, lives per round, range 1..3.
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 MASTER_STATE  input  2  game master state: 00 idle, 01 play, 10 win, 11 lost.
REQ-007 TARGET_REACHED  input  1  level from game engine; a rising edge is one target hit.
REQ-008 COLLISION  input  1  level from game engine; a rising edge is one collision.
REQ-009 BTNU  input  1  debounced restart button level; a rising edge is one restart request.
REQ-010 CURRENT_SCORE  output  4  registered score, 0..10.
REQ-011 GAME_OVER  output  1  registered loss flag.
REQ-012 LIVES  output  2  registered remaining lives.
REQ-013 TIME_LEFT  output  6  registered remaining seconds.
REQ-014 SCORE_EVENT  output  1  one-cycle pulse on each score increment.

Function
REQ-015 Rising edges are detected against one-cycle-delayed copies of TARGET_REACHED, COLLISION and BTNU; delay registers update every cycle in every state.
REQ-016 Idle (00): outputs held at reset values every cycle; prescaler cleared; BTNU ignored.
REQ-017 Play (01) with GAME_OVER=0 is the only condition in which hits, collisions and timer ticks are processed.
REQ-018 Target hit: score increments by 1 on the cycle after the edge sample; SCORE_EVENT pulses in that same cycle; score saturates at 10 with no pulse at 10.
REQ-019 Collision: LIVES decrements by 1; a collision at LIVES=1 sets LIVES=0 and GAME_OVER=1 in the same cycle.
REQ-020 Prescaler counts 0..TICKS_PER_SEC-1 in play; at terminal count it wraps to 0 and TIME_LEFT decrements; a decrement from 1 to 0 sets GAME_OVER=1.
REQ-021 Prescaler holds its value, without clearing, in win and lost states and while GAME_OVER=1.
REQ-022 Same-cycle hit that makes score 10: win has priority; a collision or timeout that cycle is discarded (LIVES, TIME_LEFT, GAME_OVER unchanged).
REQ-023 Same-cycle hit (score below 10 after increment) and collision/timeout: both applied; loss may assert.
REQ-024 Same-cycle last-life collision and timeout: LIVES=0, TIME_LEFT=0, GAME_OVER=1.
REQ-025 Once GAME_OVER=1, score, LIVES and TIME_LEFT are frozen until restart or idle.
REQ-026 Win (10): all values frozen; BTNU edge sets score 0, LIVES START_LIVES, TIME_LEFT TIME_LIMIT, prescaler 0 in one cycle.
REQ-027 Lost (11): BTNU edge performs the REQ-026 restore and clears GAME_OVER in the same cycle.
REQ-028 A BTNU edge in play is ignored.
REQ-029 Any MASTER_STATE change to 00 restores reset values on the next edge, irrespective of GAME_OVER.

Reset
REQ-030 RESET=1 sets score 0, GAME_OVER 0, LIVES START_LIVES, TIME_LEFT TIME_LIMIT, SCORE_EVENT 0, prescaler 0, edge-delay registers 0.
REQ-031 RESET has priority over every event in the same cycle, including mid-round.
REQ-032 An input held high across reset release, with MASTER_STATE=01, counts as one edge on the first post-reset sample.

Verification (TICKS_PER_SEC=4, TIME_LIMIT=3, START_LIVES=3)
REQ-033 State 01, 10 separate TARGET_REACHED pulses -> score 1..10, 10 SCORE_EVENT pulses; 11th pulse -> score stays 10, no pulse.
REQ-034 State 01, 3 COLLISION pulses -> LIVES 2,1,0; GAME_OVER=1 with third; later hits leave score unchanged.
REQ-035 State 01, idle 12 cycles -> TIME_LEFT 2,1,0 every 4 cycles; GAME_OVER=1 at 0; state 11 plus BTNU edge -> GAME_OVER 0, TIME_LEFT 3, LIVES 3, score 0.
REQ-036 Score 9, LIVES 1; hit and collision same cycle -> score 10, LIVES 1, GAME_OVER 0.
REQ-037 Score 5, LIVES 2, TIME_LEFT 2 mid-round; RESET pulse with simultaneous hit -> score 0, LIVES 3, TIME_LEFT 3, no SCORE_EVENT.
REQ-038 State 10, score 10, BTNU held 5 cycles -> single restore to score 0; no further effect until BTNU falls and rises.
